// File: rtl/rx_pattern_checker.sv
// Serial pattern checker: header search, one-frame verify, then per-bit BER tracking with lock loss.
// Optional PATTERN_INVERT_DETECT_EN also acquires on the bitwise-inverted header (MSK sign ambiguity).
module rx_pattern_checker #(
  parameter int               FDW         = 256,
  parameter logic [FDW-1:0]   FIXED_DATA  = '0,
  parameter int               WIN         = 32,
  parameter int               ERR_THRESH  = 8,
  parameter int               LOSS_FRAMES = 2,
  parameter int               CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_i,
  input  logic             data_val_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             inverted_o,
  output logic             bit_err_o,
  output logic             lock_lost_o,
  output logic [CNT_W-1:0] bits_cnt_o,
  output logic [CNT_W-1:0] errs_cnt_o,
  output logic [CNT_W-1:0] frames_cnt_o
);

  localparam int PTR_W = $clog2(FDW);
  localparam int FEC_W = $clog2(FDW + 1);
  localparam int BAD_W = $clog2(LOSS_FRAMES + 1);

  localparam logic [WIN-1:0]   HDR       = FIXED_DATA[FDW-1 -: WIN];
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FDW - 1);
  localparam logic [PTR_W-1:0] PTR_START = PTR_W'(WIN % FDW);
  localparam logic [BAD_W-1:0] BAD_LIMIT = BAD_W'(LOSS_FRAMES);
  localparam int unsigned      THRESH    = ERR_THRESH;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIN-1:0]   win_q, win_shift;
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [FEC_W-1:0] fec_q, fec_d, fec_total;
  logic [BAD_W-1:0] bad_q, bad_d, bad_inc;
  logic             inv_q, inv_d;
  logic             bit_err_q, bit_err_d;
  logic             lock_lost_q, lock_lost_d;
  logic             bits_inc, errs_inc, frames_inc;
  logic [CNT_W-1:0] bits_q, errs_q, frames_q;

  logic             exp_bit, mismatch, frame_end, frame_bad;
  logic             true_match, inv_match;
  logic             win_msb_unused;

  // The header compare includes the bit arriving this cycle, so look at the shifted window.
  assign win_shift      = {win_q[WIN-2:0], data_i};
  assign win_msb_unused = win_q[WIN-1];

  assign exp_bit   = FIXED_DATA[PTR_LAST - ptr_q] ^ inv_q;
  assign mismatch  = data_i ^ exp_bit;
  assign frame_end = (ptr_q == PTR_LAST);
  assign ptr_inc   = frame_end ? '0 : ptr_q + PTR_W'(1);
  assign fec_total = fec_q + FEC_W'(mismatch);
  assign frame_bad = (32'(fec_total) > THRESH);
  assign bad_inc   = bad_q + BAD_W'(1);

  assign true_match = (win_shift == HDR);
`ifdef PATTERN_INVERT_DETECT_EN
  assign inv_match  = (win_shift == ~HDR);
`else
  assign inv_match  = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    fec_d       = fec_q;
    bad_d       = bad_q;
    inv_d       = inv_q;
    bit_err_d   = 1'b0;
    lock_lost_d = 1'b0;
    bits_inc    = 1'b0;
    errs_inc    = 1'b0;
    frames_inc  = 1'b0;

    if (data_val_i) begin
      unique case (state_q)
        SEARCH: begin
          if (true_match || inv_match) begin
            inv_d   = !true_match;
            ptr_d   = PTR_START;
            fec_d   = '0;
            state_d = VERIFY;
          end
        end

        VERIFY: begin
          ptr_d = ptr_inc;
          if (frame_end) begin
            fec_d   = '0;
            bad_d   = '0;
            state_d = frame_bad ? SEARCH : LOCKED;
          end else begin
            fec_d = fec_total;
          end
        end

        LOCKED: begin
          ptr_d     = ptr_inc;
          bits_inc  = 1'b1;
          errs_inc  = mismatch;
          bit_err_d = mismatch;
          if (frame_end) begin
            frames_inc = 1'b1;
            fec_d      = '0;
            if (!frame_bad) begin
              bad_d = '0;
            end else if (bad_inc == BAD_LIMIT) begin
              bad_d       = '0;
              lock_lost_d = 1'b1;
              state_d     = SEARCH;
            end else begin
              bad_d = bad_inc;
            end
          end else begin
            fec_d = fec_total;
          end
        end

        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= SEARCH;
      win_q       <= '0;
      ptr_q       <= '0;
      fec_q       <= '0;
      bad_q       <= '0;
      inv_q       <= 1'b0;
      bit_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fec_q       <= fec_d;
      bad_q       <= bad_d;
      inv_q       <= inv_d;
      bit_err_q   <= bit_err_d;
      lock_lost_q <= lock_lost_d;
      if (data_val_i) begin
        win_q <= win_shift;
      end
    end
  end

  // Saturating statistics; a clear wins over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_q   <= '0;
      errs_q   <= '0;
      frames_q <= '0;
    end else if (clr_i) begin
      bits_q   <= '0;
      errs_q   <= '0;
      frames_q <= '0;
    end else begin
      if (bits_inc && (bits_q != '1)) begin
        bits_q <= bits_q + CNT_W'(1);
      end
      if (errs_inc && (errs_q != '1)) begin
        errs_q <= errs_q + CNT_W'(1);
      end
      if (frames_inc && (frames_q != '1)) begin
        frames_q <= frames_q + CNT_W'(1);
      end
    end
  end

  assign locked_o     = (state_q == LOCKED);
  assign inverted_o   = (state_q == LOCKED) && inv_q;
  assign bit_err_o    = bit_err_q;
  assign lock_lost_o  = lock_lost_q;
  assign bits_cnt_o   = bits_q;
  assign errs_cnt_o   = errs_q;
  assign frames_cnt_o = frames_q;

endmodule

// File: tb/tb_rx_pattern_checker.sv
// Self-checking bench for rx_pattern_checker: directed frames plus random traffic against a frame-level model.
module tb_rx_pattern_checker;

  localparam int FDW         = 256;
  localparam int WIN         = 32;
  localparam int ERR_THRESH  = 8;
  localparam int LOSS_FRAMES = 2;
  localparam int CNT_W       = 32;
  localparam logic [FDW-1:0] PAT =
    256'hB5C39A1E_4F7D2C86_0E93A5B1_7C48D26F_93E1B07A_5D2F84C3_16A9E75B_C0D4382F;

  localparam int HUNT  = 0;
  localparam int QUAL  = 1;
  localparam int TRACK = 2;
  localparam longint unsigned CMAX = (64'd1 << CNT_W) - 64'd1;

  logic             clk = 1'b0;
  logic             rst;
  logic             data_i, data_val_i, clr_i;
  logic             locked_o, inverted_o, bit_err_o, lock_lost_o;
  logic [CNT_W-1:0] bits_cnt_o, errs_cnt_o, frames_cnt_o;

  rx_pattern_checker #(
    .FDW        (FDW),
    .FIXED_DATA (PAT),
    .WIN        (WIN),
    .ERR_THRESH (ERR_THRESH),
    .LOSS_FRAMES(LOSS_FRAMES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .data_val_i  (data_val_i),
    .clr_i       (clr_i),
    .locked_o    (locked_o),
    .inverted_o  (inverted_o),
    .bit_err_o   (bit_err_o),
    .lock_lost_o (lock_lost_o),
    .bits_cnt_o  (bits_cnt_o),
    .errs_cnt_o  (errs_cnt_o),
    .frames_cnt_o(frames_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame position, phase and error tallies kept as plain integers.
  int               m_mode, m_pos, m_fe, m_bad;
  bit               m_inv, m_bit_err, m_lost;
  longint unsigned  m_bits, m_errs, m_frames;
  bit               hist[$];

  int err_pulses, lost_pulses;
  longint unsigned snap_bits, snap_errs, snap_frames;
  bit snap_locked;

  function automatic bit ref_bit(input int p);
    logic [FDW-1:0] pat;
    pat = PAT;
    return pat[FDW-1-p];
  endfunction

  function automatic bit hdr_seen(input bit flip);
    for (int k = 0; k < WIN; k++) begin
      if (hist[k] != (ref_bit(k) ^ flip)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic longint unsigned sat_inc(input longint unsigned v);
    return (v == CMAX) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = HUNT; m_pos = 0; m_fe = 0; m_bad = 0; m_inv = 1'b0;
    m_bits = 0; m_errs = 0; m_frames = 0; m_bit_err = 1'b0; m_lost = 1'b0;
    hist.delete();
    for (int k = 0; k < WIN; k++) hist.push_back(1'b0);
  endtask

  task automatic model_step(input bit b, input bit v, input bit c);
    bit miss;
    m_bit_err = 1'b0;
    m_lost    = 1'b0;
    if (v) begin
      hist.push_back(b);
      void'(hist.pop_front());
      miss = (b != (ref_bit(m_pos) ^ m_inv));
      if (m_mode == HUNT) begin
        bit hit_t, hit_i;
        hit_t = hdr_seen(1'b0);
`ifdef PATTERN_INVERT_DETECT_EN
        hit_i = hdr_seen(1'b1);
`else
        hit_i = 1'b0;
`endif
        if (hit_t || hit_i) begin
          m_inv  = !hit_t;
          m_pos  = WIN % FDW;
          m_fe   = 0;
          m_mode = QUAL;
        end
      end else if (m_mode == QUAL) begin
        m_fe += int'(miss);
        if (m_pos == FDW - 1) begin
          m_mode = (m_fe <= ERR_THRESH) ? TRACK : HUNT;
          m_fe   = 0;
          m_bad  = 0;
        end
        m_pos = (m_pos + 1) % FDW;
      end else begin
        m_bits = sat_inc(m_bits);
        if (miss) begin
          m_errs    = sat_inc(m_errs);
          m_bit_err = 1'b1;
        end
        m_fe += int'(miss);
        if (m_pos == FDW - 1) begin
          m_frames = sat_inc(m_frames);
          if (m_fe > ERR_THRESH) m_bad++;
          else m_bad = 0;
          m_fe = 0;
          if (m_bad >= LOSS_FRAMES) begin
            m_mode = HUNT;
            m_lost = 1'b1;
            m_bad  = 0;
          end
        end
        m_pos = (m_pos + 1) % FDW;
      end
    end
    if (c) begin
      m_bits = 0; m_errs = 0; m_frames = 0;
    end
  endtask

  task automatic compare_outputs();
    check("locked",   64'(locked_o),     64'(m_mode == TRACK));
    check("inverted", 64'(inverted_o),   64'((m_mode == TRACK) && m_inv));
    check("bit_err",  64'(bit_err_o),    64'(m_bit_err));
    check("lock_lost",64'(lock_lost_o),  64'(m_lost));
    check("bits_cnt", 64'(bits_cnt_o),   m_bits);
    check("errs_cnt", 64'(errs_cnt_o),   m_errs);
    check("frames_cnt",64'(frames_cnt_o), m_frames);
  endtask

  task automatic send_bit(input bit b, input bit v, input bit c);
    data_i     = b;
    data_val_i = v;
    clr_i      = c;
    @(posedge clk);
    #1;
    model_step(b, v, c);
    if (bit_err_o === 1'b1) err_pulses++;
    if (lock_lost_o === 1'b1) lost_pulses++;
    compare_outputs();
    data_val_i = 1'b0;
    clr_i      = 1'b0;
  endtask

  task automatic send_frame(input bit inv, input logic [FDW-1:0] flips, input int clr_at);
    for (int i = 0; i < FDW; i++) begin
      send_bit(ref_bit(i) ^ inv ^ flips[i], 1'b1, i == clr_at);
      if (i == clr_at) begin
        snap_bits   = 64'(bits_cnt_o);
        snap_errs   = 64'(errs_cnt_o);
        snap_frames = 64'(frames_cnt_o);
        snap_locked = locked_o;
      end
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    data_val_i = 1'b0;
    clr_i      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    compare_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FDW-1:0] flips;
    bit saw_lock;
    int tx_pos;
    bit burst;

    rst = 1'b1; data_i = 1'b0; data_val_i = 1'b0; clr_i = 1'b0;
    err_pulses = 0; lost_pulses = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_locked", 64'(locked_o), 64'd0);
    check("reset_bits",   64'(bits_cnt_o), 64'd0);
    do_reset();

    // Clean acquisition: locked one cycle after bit 256, then two tracked frames.
    for (int i = 0; i < FDW - 1; i++) send_bit(ref_bit(i), 1'b1, 1'b0);
    check("pre_lock_bit255", 64'(locked_o), 64'd0);
    send_bit(ref_bit(FDW - 1), 1'b1, 1'b0);
    check("lock_after_bit256", 64'(locked_o), 64'd1);
    send_frame(1'b0, '0, -1);
    send_frame(1'b0, '0, -1);
    check("clean_bits",   64'(bits_cnt_o),   64'd512);
    check("clean_errs",   64'(errs_cnt_o),   64'd0);
    check("clean_frames", 64'(frames_cnt_o), 64'd2);

    // Three isolated errors in one frame.
    flips = '0; flips[10] = 1'b1; flips[100] = 1'b1; flips[200] = 1'b1;
    err_pulses = 0;
    send_frame(1'b0, flips, -1);
    check("three_err_pulses", 64'(err_pulses), 64'd3);
    check("three_err_cnt",    64'(errs_cnt_o), 64'd3);
    check("three_err_locked", 64'(locked_o),   64'd1);

    // Two consecutive frames over threshold drop lock; a clean frame relocks.
    flips = '0;
    for (int k = 0; k < 9; k++) flips[20 + 25 * k] = 1'b1;
    lost_pulses = 0;
    send_frame(1'b0, flips, -1);
    check("one_bad_still_locked", 64'(locked_o), 64'd1);
    send_frame(1'b0, flips, -1);
    check("loss_pulse_now",  64'(lock_lost_o), 64'd1);
    check("loss_pulse_count",64'(lost_pulses), 64'd1);
    check("loss_unlocked",   64'(locked_o),    64'd0);
    send_frame(1'b0, '0, -1);
    check("relock", 64'(locked_o), 64'd1);

    // Clear coincident with an erroneous bit.
    flips = '0; flips[50] = 1'b1;
    send_frame(1'b0, flips, 50);
    check("clr_bits",   snap_bits,   64'd0);
    check("clr_errs",   snap_errs,   64'd0);
    check("clr_frames", snap_frames, 64'd0);
    check("clr_locked", 64'(snap_locked), 64'd1);

    // Verify frame over threshold returns to search without touching counters.
    do_reset();
    flips = '0;
    for (int k = 0; k < 9; k++) flips[40 + k] = 1'b1;
    send_frame(1'b0, flips, -1);
    check("vfail_locked", 64'(locked_o),     64'd0);
    check("vfail_bits",   64'(bits_cnt_o),   64'd0);
    check("vfail_errs",   64'(errs_cnt_o),   64'd0);
    check("vfail_frames", 64'(frames_cnt_o), 64'd0);
    send_frame(1'b0, '0, -1);
    check("vfail_relock", 64'(locked_o), 64'd1);

    // Asynchronous reset mid-frame clears outputs before any clock edge.
    send_frame(1'b0, '0, -1);
    for (int i = 0; i < 100; i++) send_bit(ref_bit(i) ^ (i == 7), 1'b1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_locked", 64'(locked_o),     64'd0);
    check("arst_bit_err",64'(bit_err_o),    64'd0);
    check("arst_bits",   64'(bits_cnt_o),   64'd0);
    check("arst_errs",   64'(errs_cnt_o),   64'd0);
    check("arst_frames", 64'(frames_cnt_o), 64'd0);
    do_reset();

    // Inverted stream.
    saw_lock = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FDW; i++) begin
        send_bit(!ref_bit(i), 1'b1, 1'b0);
        if (locked_o === 1'b1) saw_lock = 1'b1;
      end
    end
`ifdef PATTERN_INVERT_DETECT_EN
    check("inv_locked",   64'(locked_o),   64'd1);
    check("inv_flag",     64'(inverted_o), 64'd1);
    check("inv_errs",     64'(errs_cnt_o), 64'd0);
    check("inv_bits",     64'(bits_cnt_o), 64'd512);
`else
    check("inv_never_locks", 64'(saw_lock), 64'd0);
`endif

    // Random traffic with gaps, error bursts and occasional clears.
    do_reset();
    tx_pos = 0;
    burst  = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit v, b, c;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 299) == 0);
      if (v) begin
        bit e;
        e = burst ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
        b = ref_bit(tx_pos) ^ e;
        tx_pos = (tx_pos + 1) % FDW;
        if (tx_pos == 0) burst = ($urandom_range(0, 2) == 0);
      end else begin
        b = 1'($urandom);
      end
      send_bit(b, v, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
